mod_74x163_n: RTL
=================

# mod_74x163_n

Parametrised synchronous binary counter built from cascaded 4-bit 74x163-style slices. It provides synchronous clear, parallel load, the ENP/ENT count enables, and a ripple-carry output. It is the sequential successor to the fixed-width quad gate mappings, and is the target cell for counter inference in the 74xx techmap flow. The WIDTH/4 slices map one-to-one onto physical 74x163 packages, and the per-slice carries are exposed for board-level chaining.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise)
- SLICES, WIDTH/4, derived; number of 74x163 packages; not to be overridden

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high; clears all state
- CLR_N  in  1  synchronous clear, active-low (74x163 semantics)
- LOAD_N  in  1  synchronous parallel load, active-low
- ENP  in  1  count enable P
- ENT  in  1  count enable T; also gates the carry outputs
- D  in  WIDTH  parallel load data
- Q  out  WIDTH  counter value, registered
- CO  out  SLICES  per-slice ripple carry; CO[k] is the RCO of slice k (bits 4k+3:4k)
- RCO  out  1  whole-counter ripple carry; equals CO[SLICES-1]
- WRAP  out  1  registered one-cycle pulse; high in the cycle after the counter wraps
- DN  in  1  count direction; present only with MOD_74X163_N_UPDOWN_EN

## Operation
- Priority at each rising CLK edge, highest first:
  - RST: Q←0, WRAP←0
  - else !CLR_N: Q←0, WRAP←0
  - else !LOAD_N: Q←D, WRAP←0
  - else ENP&ENT: count
  - else hold Q, WRAP←0
- Count, up mode: Q←Q+1 modulo 2^WIDTH.
- Slice enables: slice k increments only when ENP, ENT, and CO[k-1] are all set. Slice 0 uses ENT directly. The net effect is a single WIDTH-bit increment.
- Carry (up mode): CO[0] = ENT & (Q[3:0]==4'hF). For k>0, CO[k] = CO[k-1] & (slice k == 4'hF).
- CO and RCO are combinational from Q and ENT. ENP does not affect the carries, matching 74x163 behaviour.
- WRAP←1 only when the count actually occurs and Q is at its terminal value (all ones for up counting). A load or clear in that cycle suppresses WRAP.
- Load and clear ignore ENP and ENT.
- No other FSM states exist; all state is held in Q and WRAP.

## Timing
- Q latency is 1 cycle from the qualifying edge; there is no pipeline.
- CO and RCO follow Q and ENT combinationally within the same cycle.
- WRAP is high for exactly one cycle, the cycle following the wrapping edge.
- Reset values: Q=0, WRAP=0. With ENT=1 after reset, CO=0 and RCO=0 in up mode.
- RST asserted mid-count takes effect at the next edge regardless of CLR_N, LOAD_N, or the enables.
- RST and LOAD_N both active: RST wins.
- CLR_N and LOAD_N both active: the clear wins.
- ENT=0 freezes the counter and forces every CO bit to 0, even when ENP=1.

## Configuration
MOD_74X163_N_UPDOWN_EN

Defined:
- The DN port exists. DN=1 counts Q←Q-1 modulo 2^WIDTH.
- In down mode the per-slice terminal value is 4'h0: CO[0] = ENT & (Q[3:0]==0), and CO[k] is chained on zero slices.
- WRAP fires on the transition 0 → all ones.
- DN is sampled each cycle. A change of direction takes effect on the next count edge, and the carries switch combinationally.
- Reset value of Q stays 0. This means RCO=ENT immediately after reset when DN=1.

Undefined:
- The DN port is absent and the counter counts up only.
- The down-mode carry logic is not generated.

## Test plan
- WIDTH=8, RST=1 for 2 cycles, then RST=0, ENP=ENT=1, CLR_N=LOAD_N=1 for 256 cycles → Q steps 0x00..0xFF then 0x00. RCO=1 only while Q=0xFF. WRAP=1 for exactly the one cycle in which Q=0x00 after the wrap.
- WIDTH=8, load D=0x0E then count → Q goes 0x0E, 0x0F, 0x10. CO[0]=1 only at 0x0F. Slice 1 increments exactly once.
- Q=0xFF with ENT=1, ENP=0 → Q holds and RCO=1. Then set ENT=0 → RCO=0 in the same cycle and Q still holds.
- Q=0xFF, count enabled, LOAD_N=0, D=0x5A → Q=0x5A and WRAP=0. Repeat with CLR_N=0 as well → Q=0x00. Repeat with RST=1 → Q=0x00 and WRAP=0.
- WIDTH=12, load 0x7FF and count → Q=0x800, with CO toggling correctly across all three slices.
- With MOD_74X163_N_UPDOWN_EN, WIDTH=8, DN=1 from Q=0x01 → Q goes 0x00, 0xFF. RCO=1 at Q=0x00 and WRAP pulses after 0xFF appears. Set DN=0 at Q=0xFF → next Q=0x00.

Source files
------------

// File: rtl/mod_74x163_n.sv
// rtl/mod_74x163_n.sv - WIDTH-bit counter of cascaded 74x163 slices with clear, load, ENP/ENT and ripple carries
// Optional down counting with the DN port when MOD_74X163_N_UPDOWN_EN is defined.
module mod_74x163_n #(
  parameter int WIDTH  = 8,
  parameter int SLICES = WIDTH / 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR_N,
  input  logic              LOAD_N,
  input  logic              ENP,
  input  logic              ENT,
`ifdef MOD_74X163_N_UPDOWN_EN
  input  logic              DN,
`endif
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic [SLICES-1:0] CO,
  output logic              RCO,
  output logic              WRAP
);

  generate
    if ((WIDTH < 4) || (WIDTH % 4 != 0) || (SLICES != WIDTH / 4)) begin : g_bad_width
      $error("mod_74x163_n: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic              dn;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              wrap_q, wrap_d;
  logic [WIDTH-1:0]  cnt_nxt;
  logic [SLICES-1:0] co_c;
  logic [3:0]        slice_v;
  logic              carry;
  logic              term;

`ifdef MOD_74X163_N_UPDOWN_EN
  assign dn = DN;
`else
  assign dn = 1'b0;
`endif

  // Each slice steps only when every lower slice sits at its terminal value,
  // so the cascade behaves as one WIDTH-bit increment/decrement.
  always_comb begin
    cnt_nxt = q_q;
    co_c    = '0;
    carry   = ENT;
    slice_v = 4'h0;
    term    = 1'b0;
    for (int k = 0; k < SLICES; k++) begin
      slice_v = q_q[4*k +: 4];
      term    = dn ? (slice_v == 4'h0) : (slice_v == 4'hF);
      if (ENP && carry) begin
        cnt_nxt[4*k +: 4] = dn ? (slice_v - 4'd1) : (slice_v + 4'd1);
      end
      carry   = carry & term;
      co_c[k] = carry;
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!CLR_N) begin
      q_d = '0;
    end else if (!LOAD_N) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d    = cnt_nxt;
      wrap_d = co_c[SLICES-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign CO   = co_c;
  assign RCO  = co_c[SLICES-1];
  assign WRAP = wrap_q;

endmodule
